// File: rtl/pipeline_pkg.sv
// pipeline_pkg
//   Shared definitions for the pipeline hazard control slice.
//   - state_e   : hazard FSM encoding (RUN, STALL, FREEZE)
//   - REG_W     : architectural register-number width
//   - REG_ZERO  : register $0, which never carries a real dependency
//   - load_use_hazard() : load-use dependency test between the ID operands
//                         and the destination of a load sitting in EX
package pipeline_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FREEZE = 2'd2
  } state_e;

  // A load into $0 is discarded by the register file, so it can never
  // feed a dependent instruction.
  function automatic logic load_use_hazard(
    input logic             mem_read_ex,
    input logic [REG_W-1:0] rt_ex,
    input logic [REG_W-1:0] rs_id,
    input logic [REG_W-1:0] rt_id,
    input logic             uses_rt_id
  );
    return mem_read_ex && (rt_ex != REG_ZERO) &&
           ((rt_ex == rs_id) || (uses_rt_id && (rt_ex == rt_id)));
  endfunction

endpackage

// File: rtl/hazard_stats.sv
// hazard_stats
//   Two saturating event counters for the hazard unit.
//   Ports:
//     clk, reset      : clock and asynchronous active-high reset
//     stall_inc       : one bubble inserted this cycle
//     flush_inc       : one redirect flush applied this cycle
//     stall_cnt       : bubbles inserted since reset (saturates at all-ones)
//     flush_cnt       : redirect flushes since reset (saturates at all-ones)
module hazard_stats #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_inc,
  input  logic             flush_inc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_inc && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
    if (flush_inc && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit
//   Front-end pipeline control: drives the load enables and flushes of the
//   PC, IF_ID and ID_EX registers.
//   - Load-use hazard  : hold PC and IF_ID, insert LOAD_STALL_CYCLES bubbles
//                        into ID_EX.
//   - Redirect (taken branch / jump in EX): flush IF_ID and ID_EX.
//   - Mem_busy         : freeze PC, IF_ID and ID_EX; outstanding bubbles are
//                        held and issued after the memory releases.
//   Priority: Mem_busy > redirect > hazard.
//   Outputs are Mealy (combinational from state and inputs). While reset is
//   asserted all outputs sit at their defaults.
//
//   Ports:
//     clk, reset                       : clock, async active-high reset
//     Rs_ID, Rt_ID, UsesRt_ID          : operands of the instruction in ID
//     Rt_EX, MemRead_EX                : load destination in EX
//     Branch_taken_EX, Jump_EX         : redirect resolved in EX
//     Mem_busy                         : data memory not ready
//     PC_Write, IF_ID_Write, ID_EX_Write : load enables
//     IF_ID_Flush, ID_EX_Flush         : NOP / bubble insertion
//     Stall_cnt, Flush_cnt             : statistics (zero unless enabled)
//     dbg_state                        : current FSM state
//
//   Build option: define HAZARD_STATS_EN to instantiate the statistics
//   counters; otherwise Stall_cnt/Flush_cnt are tied to 0.
module hazard_unit
  import pipeline_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] Rs_ID,
  input  logic [REG_W-1:0] Rt_ID,
  input  logic             UsesRt_ID,
  input  logic [REG_W-1:0] Rt_EX,
  input  logic             MemRead_EX,
  input  logic             Branch_taken_EX,
  input  logic             Jump_EX,
  input  logic             Mem_busy,
  output logic             PC_Write,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Flush,
  output logic             ID_EX_Write,
  output logic [CNT_W-1:0] Stall_cnt,
  output logic [CNT_W-1:0] Flush_cnt,
  output state_e           dbg_state
);

  localparam int LEFT_W = 4;
  // Bubbles still owed after the first one issued in the hazard cycle.
  localparam logic [LEFT_W-1:0] STALL_RELOAD = LEFT_W'(LOAD_STALL_CYCLES - 1);

  state_e            state_q, state_d;
  logic [LEFT_W-1:0] left_q, left_d;

  logic hazard;
  logic redirect;
  logic act_freeze;
  logic act_stall;

  always_comb begin
    hazard   = load_use_hazard(MemRead_EX, Rt_EX, Rs_ID, Rt_ID, UsesRt_ID);
    redirect = Branch_taken_EX | Jump_EX;

    state_d     = state_q;
    left_d      = left_q;
    PC_Write    = 1'b1;
    IF_ID_Write = 1'b1;
    ID_EX_Write = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    act_freeze  = 1'b0;
    act_stall   = 1'b0;

    // Pick which behaviour applies this cycle. A FREEZE exit cycle behaves
    // like STALL when bubbles are still owed, otherwise like RUN, so the
    // total bubble count per hazard is unaffected by the freeze.
    case (state_q)
      RUN:     act_freeze = Mem_busy;
      STALL: begin
        act_freeze = Mem_busy;
        act_stall  = !Mem_busy;
      end
      FREEZE: begin
        act_freeze = Mem_busy;
        act_stall  = !Mem_busy && (left_q != '0);
      end
      default: ;
    endcase

    if (act_freeze) begin
      PC_Write    = 1'b0;
      IF_ID_Write = 1'b0;
      ID_EX_Write = 1'b0;
      state_d     = FREEZE;
    end else if (act_stall) begin
      if (redirect) begin
        // The stalled instruction is on the wrong path: drop it and the
        // remaining bubbles.
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
        left_d      = '0;
        state_d     = RUN;
      end else begin
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Flush = 1'b1;
        left_d      = left_q - 1'b1;
        state_d     = (left_q == LEFT_W'(1)) ? RUN : STALL;
      end
    end else begin
      state_d = RUN;
      if (redirect) begin
        IF_ID_Flush = 1'b1;
        ID_EX_Flush = 1'b1;
      end else if (hazard) begin
        PC_Write    = 1'b0;
        IF_ID_Write = 1'b0;
        ID_EX_Flush = 1'b1;
        if (STALL_RELOAD != '0) begin
          left_d  = STALL_RELOAD;
          state_d = STALL;
        end
      end
    end

    // Outputs return to defaults as soon as reset is asserted, without
    // waiting for a clock edge.
    if (reset) begin
      PC_Write    = 1'b1;
      IF_ID_Write = 1'b1;
      ID_EX_Write = 1'b1;
      IF_ID_Flush = 1'b0;
      ID_EX_Flush = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      left_q  <= '0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
    end
  end

  assign dbg_state = state_q;

`ifdef HAZARD_STATS_EN
  // A bubble flushes ID_EX alone; a redirect flushes IF_ID as well.
  logic stall_inc;
  logic flush_inc;
  assign stall_inc = ID_EX_Flush & ~IF_ID_Flush;
  assign flush_inc = IF_ID_Flush;

  hazard_stats #(
    .CNT_W(CNT_W)
  ) u_stats (
    .clk      (clk),
    .reset    (reset),
    .stall_inc(stall_inc),
    .flush_inc(flush_inc),
    .stall_cnt(Stall_cnt),
    .flush_cnt(Flush_cnt)
  );
`else
  assign Stall_cnt = '0;
  assign Flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit
//   Two instances share one stimulus stream: LOAD_STALL_CYCLES = 1 and 3.
//   Control outputs are packed as {PC_Write, IF_ID_Write, ID_EX_Write,
//   IF_ID_Flush, ID_EX_Flush}. The reference model tracks only the number of
//   owed bubbles per instance and applies the priority rules directly.
module tb_hazard_unit;
  import pipeline_pkg::*;

  localparam int CNT_W = 16;
  localparam logic [4:0] CTL_DEF    = 5'b11100;
  localparam logic [4:0] CTL_BUBBLE = 5'b00101;
  localparam logic [4:0] CTL_REDIR  = 5'b11111;
  localparam logic [4:0] CTL_FROZEN = 5'b00000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0] Rs_ID, Rt_ID, Rt_EX;
  logic       UsesRt_ID, MemRead_EX, Branch_taken_EX, Jump_EX, Mem_busy;

  logic [1:0]       pc_w, ifid_w, idex_w, ifid_f, idex_f;
  logic [CNT_W-1:0] stall_c [2];
  logic [CNT_W-1:0] flush_c [2];
  state_e           st      [2];

  hazard_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(CNT_W)) u_dut1 (
    .clk(clk), .reset(reset), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .UsesRt_ID(UsesRt_ID), .Rt_EX(Rt_EX), .MemRead_EX(MemRead_EX),
    .Branch_taken_EX(Branch_taken_EX), .Jump_EX(Jump_EX), .Mem_busy(Mem_busy),
    .PC_Write(pc_w[0]), .IF_ID_Write(ifid_w[0]), .IF_ID_Flush(ifid_f[0]),
    .ID_EX_Flush(idex_f[0]), .ID_EX_Write(idex_w[0]),
    .Stall_cnt(stall_c[0]), .Flush_cnt(flush_c[0]), .dbg_state(st[0])
  );

  hazard_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(CNT_W)) u_dut3 (
    .clk(clk), .reset(reset), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
    .UsesRt_ID(UsesRt_ID), .Rt_EX(Rt_EX), .MemRead_EX(MemRead_EX),
    .Branch_taken_EX(Branch_taken_EX), .Jump_EX(Jump_EX), .Mem_busy(Mem_busy),
    .PC_Write(pc_w[1]), .IF_ID_Write(ifid_w[1]), .IF_ID_Flush(ifid_f[1]),
    .ID_EX_Flush(idex_f[1]), .ID_EX_Write(idex_w[1]),
    .Stall_cnt(stall_c[1]), .Flush_cnt(flush_c[1]), .dbg_state(st[1])
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] dut_ctl(input int d);
    return {pc_w[d], ifid_w[d], idex_w[d], ifid_f[d], idex_f[d]};
  endfunction

  // ---------------- reference model ----------------
  int     lsc     [2] = '{1, 3};
  int     m_left  [2];
  int     m_stall [2];
  int     m_flush [2];
  state_e m_state [2];
  logic [4:0] obs [2];

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic int stats_exp(input int v);
`ifdef HAZARD_STATS_EN
    return sat(v);
`else
    return 0 * v;
`endif
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_left[d]  = 0;
      m_stall[d] = 0;
      m_flush[d] = 0;
      m_state[d] = RUN;
    end
  endtask

  // Applies the priority rules to the current inputs for instance d.
  task automatic model_step(input int d, output logic [4:0] ctl,
                            output int left_n, output bit bub, output bit fl);
    bit haz;
    haz = MemRead_EX && (Rt_EX != 5'd0) &&
          ((Rt_EX == Rs_ID) || (UsesRt_ID && (Rt_EX == Rt_ID)));
    left_n = m_left[d];
    bub    = 1'b0;
    fl     = 1'b0;
    if (Mem_busy) begin
      ctl = CTL_FROZEN;
    end else if (Branch_taken_EX || Jump_EX) begin
      ctl = CTL_REDIR; left_n = 0; fl = 1'b1;
    end else if (m_left[d] > 0) begin
      ctl = CTL_BUBBLE; left_n = m_left[d] - 1; bub = 1'b1;
    end else if (haz) begin
      ctl = CTL_BUBBLE; left_n = lsc[d] - 1; bub = 1'b1;
    end else begin
      ctl = CTL_DEF;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    Rs_ID = '0; Rt_ID = '0; Rt_EX = '0; UsesRt_ID = 1'b0; MemRead_EX = 1'b0;
    Branch_taken_EX = 1'b0; Jump_EX = 1'b0; Mem_busy = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] r);
    MemRead_EX = 1'b1; Rt_EX = r; Rs_ID = r; Rt_ID = 5'd0; UsesRt_ID = 1'b0;
  endtask

  // Called just after a rising edge with inputs already driven: checks at
  // the falling edge, then advances the model at the next rising edge.
  task automatic run_cycle();
    logic [4:0] ctl_e [2];
    int         left_n [2];
    bit         bub [2];
    bit         fl [2];
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      model_step(d, ctl_e[d], left_n[d], bub[d], fl[d]);
      obs[d] = dut_ctl(d);
      check($sformatf("ctl[L=%0d]", lsc[d]), 32'(obs[d]), 32'(ctl_e[d]));
      check($sformatf("state[L=%0d]", lsc[d]), 32'(st[d]), 32'(m_state[d]));
      check($sformatf("stall_cnt[L=%0d]", lsc[d]), 32'(stall_c[d]), 32'(stats_exp(m_stall[d])));
      check($sformatf("flush_cnt[L=%0d]", lsc[d]), 32'(flush_c[d]), 32'(stats_exp(m_flush[d])));
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      m_left[d] = left_n[d];
      if (bub[d]) m_stall[d]++;
      if (fl[d])  m_flush[d]++;
      m_state[d] = Mem_busy ? FREEZE : ((m_left[d] > 0) ? STALL : RUN);
    end
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_ctl[L=%0d]", tag, lsc[d]), 32'(dut_ctl(d)), 32'(CTL_DEF));
      check($sformatf("%s_state[L=%0d]", tag, lsc[d]), 32'(st[d]), 32'(RUN));
      check($sformatf("%s_stall_cnt[L=%0d]", tag, lsc[d]), 32'(stall_c[d]), 32'd0);
      check($sformatf("%s_flush_cnt[L=%0d]", tag, lsc[d]), 32'(flush_c[d]), 32'd0);
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int bubbles [2];
    int frozen;

    set_idle();
    model_reset();
    reset = 1'b1;
    #3;
    check_reset_values("reset");
    #4 reset = 1'b0;
    @(posedge clk); #1;

    // Load-use on Rs: 1 bubble (L=1) and 3 bubbles (L=3).
    bubbles = '{0, 0};
    set_load_use(5'd2);
    run_cycle();
    for (int d = 0; d < 2; d++) if (obs[d] == CTL_BUBBLE) bubbles[d]++;
    set_idle();
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      for (int d = 0; d < 2; d++) if (obs[d] == CTL_BUBBLE) bubbles[d]++;
    end
    check("bubbles[L=1]", 32'(bubbles[0]), 32'd1);
    check("bubbles[L=3]", 32'(bubbles[1]), 32'd3);

    // Load into $0 never stalls.
    set_load_use(5'd0);
    run_cycle();
    check("r0_no_stall", 32'(obs[1]), 32'(CTL_DEF));

    // Rt match ignored when the ID instruction does not read Rt.
    set_idle();
    MemRead_EX = 1'b1; Rt_EX = 5'd5; Rt_ID = 5'd5; Rs_ID = 5'd1; UsesRt_ID = 1'b0;
    run_cycle();
    check("rt_unused_no_stall", 32'(obs[0]), 32'(CTL_DEF));
    UsesRt_ID = 1'b1;
    run_cycle();
    check("rt_used_stall", 32'(obs[0]), 32'(CTL_BUBBLE));
    set_idle();
    repeat (3) run_cycle();

    // Taken branch and jump win over a simultaneous hazard.
    set_load_use(5'd7);
    Branch_taken_EX = 1'b1;
    run_cycle();
    check("branch_over_hazard", 32'(obs[1]), 32'(CTL_REDIR));
    set_idle();
    run_cycle();
    check("branch_no_stall_after", 32'(obs[1]), 32'(CTL_DEF));
    set_load_use(5'd3);
    Jump_EX = 1'b1;
    run_cycle();
    check("jump_over_hazard", 32'(obs[0]), 32'(CTL_REDIR));
    set_idle();
    run_cycle();

    // Mem_busy for 4 cycles while L=3 owes one bubble.
    set_load_use(5'd4);
    run_cycle();
    set_idle();
    run_cycle();
    Mem_busy = 1'b1;
    frozen = 0;
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      if (obs[1] == CTL_FROZEN) frozen++;
    end
    check("frozen_cycles[L=3]", 32'(frozen), 32'd4);
    Mem_busy = 1'b0;
    run_cycle();
    check("bubble_after_release", 32'(obs[1]), 32'(CTL_BUBBLE));
    run_cycle();
    check("run_after_release", 32'(obs[1]), 32'(CTL_DEF));

    // Asynchronous reset in the middle of a STALL cycle.
    set_load_use(5'd6);
    run_cycle();
    #2 reset = 1'b1;
    #1;
    check_reset_values("mid_stall_reset");
    model_reset();
    set_idle();
    #2 reset = 1'b0;
    @(posedge clk); #1;
    run_cycle();
    check("post_reset_run", 32'(obs[1]), 32'(CTL_DEF));

    // Randomized traffic over a small register set to hit many dependencies.
    for (int i = 0; i < 1500; i++) begin
      Rs_ID           = 5'($urandom_range(0, 3));
      Rt_ID           = 5'($urandom_range(0, 3));
      Rt_EX           = 5'($urandom_range(0, 3));
      UsesRt_ID       = 1'($urandom_range(0, 1));
      MemRead_EX      = ($urandom_range(0, 99) < 50);
      Branch_taken_EX = ($urandom_range(0, 99) < 8);
      Jump_EX         = ($urandom_range(0, 99) < 4);
      Mem_busy        = ($urandom_range(0, 99) < 15);
      run_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Pipeline control block that drives the write-enable and flush inputs of the PC, IF_ID and ID_EX registers.
- Detects load-use hazards from ID-stage operands against the EX-stage load destination and inserts LOAD_STALL_CYCLES bubbles into ID_EX.
- Flushes IF_ID and ID_EX on a taken branch or jump resolved in EX.
- Freezes the whole front end while data memory reports busy.

Parameters:
- LOAD_STALL_CYCLES, 1, number of bubbles inserted per load-use hazard (1..15).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  pipeline clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Rs_ID  input  5  source register 1 of the instruction in ID.
- Rt_ID  input  5  source register 2 of the instruction in ID.
- UsesRt_ID  input  1  instruction in ID reads Rt (R-type, store, branch).
- Rt_EX  input  5  destination of the load in EX.
- MemRead_EX  input  1  instruction in EX is a load.
- Branch_taken_EX  input  1  branch in EX resolved taken.
- Jump_EX  input  1  jump in EX.
- Mem_busy  input  1  data memory not ready; hold the pipeline.
- PC_Write  output  1  PC load enable.
- IF_ID_Write  output  1  IF_ID load enable.
- IF_ID_Flush  output  1  IF_ID loads a NOP.
- ID_EX_Flush  output  1  ID_EX loads all-zero control signals (bubble).
- ID_EX_Write  output  1  ID_EX load enable.
- Stall_cnt  output  CNT_W  bubbles inserted (HAZARD_STATS_EN only).
- Flush_cnt  output  CNT_W  redirect flushes (HAZARD_STATS_EN only).

Behaviour:
- hazard = MemRead_EX & (Rt_EX != 0) & ((Rt_EX == Rs_ID) | (UsesRt_ID & Rt_EX == Rt_ID)).
- redirect = Branch_taken_EX | Jump_EX.
- FSM states: RUN, STALL, FREEZE. Reset state RUN; stall counter resets to 0.
- Outputs are Mealy: combinational from state and inputs, no added latency. Default outputs: all write enables 1, both flushes 0.
- Priority, highest first: Mem_busy, then redirect, then hazard.
- RUN:
  - Mem_busy: PC_Write, IF_ID_Write and ID_EX_Write all 0; go to FREEZE.
  - Otherwise redirect: IF_ID_Flush=1, ID_EX_Flush=1; stay in RUN.
  - Otherwise hazard: PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1. If LOAD_STALL_CYCLES>1, load counter with LOAD_STALL_CYCLES-1 and go to STALL.
- STALL:
  - PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1; decrement counter each cycle; return to RUN when counter reaches 0 (after its last bubble).
  - Redirect in STALL: flush both registers, clear counter, go to RUN. The stalled instruction is on the wrong path.
  - Mem_busy in STALL: freeze; the counter does not decrement.
- FREEZE:
  - All write enables 0, flushes 0.
  - Exit when Mem_busy=0: go to STALL if the counter is nonzero, else RUN. Redirect and hazard are evaluated in the exit cycle as in RUN.
- Asynchronous reset mid-STALL or mid-FREEZE: state goes to RUN and counter to 0 immediately; outputs return to defaults in the same cycle.
- Reset values: PC_Write=1, IF_ID_Write=1, ID_EX_Write=1, IF_ID_Flush=0, ID_EX_Flush=0, Stall_cnt=0, Flush_cnt=0.

Optional Feature:
- Macro HAZARD_STATS_EN.
- Defined: Stall_cnt increments once per cycle with ID_EX_Flush=1 caused by a hazard or STALL. Flush_cnt increments once per redirect cycle that is not frozen. Both saturate at all-ones and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are generated.

Decomposition:
- Shared package pipeline_pkg: FSM state encoding (RUN=2'd0, STALL=2'd1, FREEZE=2'd2), register-number width constant REG_W=5, register-zero constant.
- Sub-module hazard_stats: the two saturating counters, instantiated only under HAZARD_STATS_EN.

Test Plan:
- lw $2 in EX (MemRead_EX=1, Rt_EX=2), ID add with Rs_ID=2 -> one cycle with PC_Write=0, IF_ID_Write=0, ID_EX_Flush=1, then defaults; Stall_cnt=1.
- LOAD_STALL_CYCLES=3, same hazard -> exactly 3 consecutive bubble cycles, then RUN.
- Rt_EX=0 with Rs_ID=0, MemRead_EX=1 -> no stall.
- UsesRt_ID=0, Rt_ID=Rt_EX=5 -> no stall.
- Branch_taken_EX=1 in the same cycle as a hazard -> IF_ID_Flush=1, ID_EX_Flush=1, PC_Write=1, no stall; Flush_cnt=1.
- Mem_busy high for 4 cycles during STALL with counter=1 -> all write enables 0 for 4 cycles, counter held, one bubble after release.
- reset asserted mid-STALL, between clock edges -> PC_Write=1 and both flushes 0 immediately; state RUN after release.
